// File: rtl/aes_iterative_core.sv
// aes_iterative_core
//   Iterative AES-128/192/256 cipher core. One round per clock through a single
//   round datapath; encrypt or decrypt chosen per block. Round keys come from an
//   external store addressed by rk_idx, which is decoded from registered state only.
//
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   INIT  | initial AddRoundKey (key 0 for encrypt, key NR for decrypt)
//   ROUND | rounds 1..NR, one per clock
//   DONE  | result presented on out_data until out_ready
//
// Parameters
//   NK      key length in 32-bit words (4, 6 or 8); NR = NK+6
//   DEC_EN  1: inverse datapath built and in_decrypt honoured; 0: encrypt only
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_data (byte 0 in [127:120]), in_decrypt
//   rk_idx, rk           round-key request index and the key returned for it
//   out_valid/out_ready  output handshake; out_data result block
//   busy                 high while a block is in flight (INIT/ROUND/DONE)

module aes_iterative_core #(
  parameter int NK     = 4,
  parameter bit DEC_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_decrypt,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NR = NK + 6;
  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} stateT;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers. The S-box is computed (multiplicative inverse + affine map)
  // rather than tabulated, so forward and inverse share the same inverse logic.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 = a^-1 for a != 0, and maps 0 to 0 as AES requires
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gfMul(p, p);
      r = gfMul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gfInv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] b);
    return gfInv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  // ---------------------------------------------------------------------------
  // Round transforms on the 128-bit state; byte i = row i%4, column i/4.
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = invSbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
      o[119-32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
      o[111-32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
      o[103-32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  stateT        state;
  stateT        nextState;
  logic [3:0]   round;
  logic         mode;        // 1: decrypt
  logic [127:0] dataReg;
  logic [127:0] outData;
  logic         lastRound;
  logic [127:0] encSr;
  logic [127:0] encOut;
  logic [127:0] decOut;
  logic [127:0] roundOut;

  assign lastRound = (round == NR4);

  always_comb begin
    encSr  = shiftRows(subBytes(dataReg));
    encOut = (lastRound ? encSr : mixColumns(encSr)) ^ rk;
  end

  generate
    if (DEC_EN) begin : gDec
      logic [127:0] decArk;
      always_comb begin
        decArk = invSubBytes(invShiftRows(dataReg)) ^ rk;
        decOut = lastRound ? decArk : invMixColumns(decArk);
      end
    end else begin : gNoDec
      assign decOut = '0;
    end
  endgenerate

  assign roundOut = mode ? decOut : encOut;
  assign out_data = outData;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    rk_idx    = 4'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) nextState = INIT;
      end
      INIT: begin
        rk_idx    = mode ? NR4 : 4'd0;
        nextState = ROUND;
      end
      ROUND: begin
        // decrypt walks the key schedule backwards
        rk_idx = mode ? (NR4 - round) : round;
        if (lastRound) nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataReg <= '0;
      outData <= '0;
      round   <= 4'd0;
      mode    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dataReg <= in_data;
            mode    <= in_decrypt & DEC_EN;
          end
        end
        INIT: begin
          dataReg <= dataReg ^ rk;
          round   <= 4'd1;
        end
        ROUND: begin
          dataReg <= roundOut;
          if (lastRound) begin
            outData <= roundOut;
            round   <= 4'd0;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iterative_core.sv
// tb_aes_iterative_core
//   Four core instances: NK=4, NK=6, NK=8 (all with the inverse datapath) and
//   NK=4 encrypt-only. Round keys are served from a behavioural key expansion;
//   expected blocks go into a scoreboard queue when a block is offered and are
//   popped when the core hands a result out.

module tb_aes_iterative_core;

  logic         clk;
  logic         rst_n;
  logic         inValid   [4];
  logic         inReady   [4];
  logic [127:0] inData    [4];
  logic         inDecrypt [4];
  logic [3:0]   rkIdx     [4];
  logic [127:0] rk        [4];
  logic         outValid  [4];
  logic         outReady  [4];
  logic [127:0] outData   [4];
  logic         busy      [4];

  logic [127:0] rkTab [4][15];
  logic [7:0]   sboxT [256];
  logic [7:0]   isboxT [256];
  int           nkOf [4] = '{4, 6, 8, 4};

  logic [127:0] expQ[$];
  logic [127:0] monExp;
  int nVec    = 0;
  int nErr    = 0;
  int sentCnt = 0;
  int popCnt  = 0;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  for (genvar g = 0; g < 4; g++) begin : gDut
    localparam int NKG  = (g == 1) ? 6 : ((g == 2) ? 8 : 4);
    localparam bit DECG = (g != 3);
    aes_iterative_core #(.NK(NKG), .DEC_EN(DECG)) uDut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (inValid[g]),
      .in_ready   (inReady[g]),
      .in_data    (inData[g]),
      .in_decrypt (inDecrypt[g]),
      .rk_idx     (rkIdx[g]),
      .rk         (rk[g]),
      .out_valid  (outValid[g]),
      .out_ready  (outReady[g]),
      .out_data   (outData[g]),
      .busy       (busy[g])
    );
    assign rk[g] = rkTab[g][rkIdx[g]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    while (bb != 0) begin
      if (bb[0]) r ^= aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return r;
  endfunction

  // S-box built by walking generator 3 and its inverse together
  task automatic buildSbox();
    logic [7:0] p = 8'h01;
    logic [7:0] q = 8'h01;
    logic [7:0] x;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
      sboxT[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxT[0] = 8'h63;
    for (int i = 0; i < 256; i++) isboxT[sboxT[i]] = 8'(i);
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxT[w[31:24]], sboxT[w[23:16]], sboxT[w[15:8]], sboxT[w[7:0]]};
  endfunction

  task automatic expandKey(input int d);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int nk = nkOf[d];
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subWord({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rcon;
        rcon = mul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rkTab[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] modelEnc(input int d, input logic [127:0] blk);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] k;
    logic [127:0] o;
    int nr = nkOf[d] + 6;
    k = rkTab[d][0];
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = sboxT[s[4*((c+w)%4)+w]];
      for (int c = 0; c < 4; c++) begin
        if (r < nr) begin
          s[4*c]   = mul(t[4*c], 2) ^ mul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ mul(t[4*c+1], 2) ^ mul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul(t[4*c+2], 2) ^ mul(t[4*c+3], 3);
          s[4*c+3] = mul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ mul(t[4*c+3], 2);
        end else begin
          for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
        end
      end
      k = rkTab[d][r];
      for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] modelDec(input int d, input logic [127:0] blk);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] k;
    logic [127:0] o;
    int nr = nkOf[d] + 6;
    k = rkTab[d][nr];
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      k = rkTab[d][r];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*c+w] = isboxT[s[4*((c-w+4)%4)+w]] ^ k[127-8*(4*c+w) -: 8];
      for (int c = 0; c < 4; c++) begin
        if (r > 0) begin
          s[4*c]   = mul(t[4*c], 14) ^ mul(t[4*c+1], 11) ^ mul(t[4*c+2], 13) ^ mul(t[4*c+3], 9);
          s[4*c+1] = mul(t[4*c], 9)  ^ mul(t[4*c+1], 14) ^ mul(t[4*c+2], 11) ^ mul(t[4*c+3], 13);
          s[4*c+2] = mul(t[4*c], 13) ^ mul(t[4*c+1], 9)  ^ mul(t[4*c+2], 14) ^ mul(t[4*c+3], 11);
          s[4*c+3] = mul(t[4*c], 11) ^ mul(t[4*c+1], 13) ^ mul(t[4*c+2], 9)  ^ mul(t[4*c+3], 14);
        end else begin
          for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (rst_n && outValid[d] && outReady[d]) begin
        if (expQ.size() == 0) begin
          checkEq($sformatf("sb_unexpected_d%0d", d), 128'd1, 128'd0);
        end else begin
          monExp = expQ.pop_front();
          popCnt++;
          checkEq($sformatf("out_data_d%0d", d), outData[d], monExp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns one tick after the accepting edge; inputs are scrambled afterwards
  // so a core that keeps sampling them would be caught by the scoreboard.
  task automatic sendBlock(input int d, input logic [127:0] blk, input logic dec,
                           input logic [127:0] exp);
    int n = 0;
    logic acc = 1'b0;
    inValid[d]   = 1'b1;
    inData[d]    = blk;
    inDecrypt[d] = dec;
    expQ.push_back(exp);
    sentCnt++;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = inReady[d];
      n++;
    end
    @(posedge clk);
    #1;
    inValid[d]   = 1'b0;
    inData[d]    = ~blk;
    inDecrypt[d] = ~dec;
    if (!acc) checkEq("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic measureLat(input int d, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!outValid[d] && lat < 40);
  endtask

  task automatic waitDrain(input int d);
    int n = 0;
    while ((expQ.size() != 0 || busy[d]) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) checkEq("drain_timeout", 128'd0, 128'd1);
  endtask

  // ---------------- main sequence ----------------
  int lat;
  logic [127:0] held;
  logic sawValid;
  logic stallOn;
  logic [127:0] rb;
  logic rdec;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      inValid[d] = 1'b0; inData[d] = '0; inDecrypt[d] = 1'b0; outReady[d] = 1'b1;
    end
    buildSbox();
    for (int d = 0; d < 4; d++) expandKey(d);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      checkEq($sformatf("rst_in_ready_d%0d", d), 128'(inReady[d]), 128'd1);
      checkEq($sformatf("rst_out_valid_d%0d", d), 128'(outValid[d]), 128'd0);
      checkEq($sformatf("rst_busy_d%0d", d), 128'(busy[d]), 128'd0);
      checkEq($sformatf("rst_out_data_d%0d", d), outData[d], 128'd0);
      checkEq($sformatf("rst_rk_idx_d%0d", d), 128'(rkIdx[d]), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // known-answer vectors with latency
    sendBlock(0, PT, 1'b0, CT128);
    measureLat(0, lat);
    checkEq("lat_nk4_enc", 128'(lat), 128'd11);
    waitDrain(0);
    sendBlock(0, CT128, 1'b1, PT);
    measureLat(0, lat);
    checkEq("lat_nk4_dec", 128'(lat), 128'd11);
    waitDrain(0);
    sendBlock(1, PT, 1'b0, CT192);
    measureLat(1, lat);
    checkEq("lat_nk6_enc", 128'(lat), 128'd13);
    waitDrain(1);
    sendBlock(1, CT192, 1'b1, PT);
    waitDrain(1);
    sendBlock(2, PT, 1'b0, CT256);
    measureLat(2, lat);
    checkEq("lat_nk8_enc", 128'(lat), 128'd15);
    waitDrain(2);
    sendBlock(2, CT256, 1'b1, PT);
    waitDrain(2);

    // back-pressure in DONE
    outReady[0] = 1'b0;
    sendBlock(0, PT, 1'b0, CT128);
    measureLat(0, lat);
    checkEq("lat_stall", 128'(lat), 128'd11);
    held = outData[0];
    for (int i = 0; i < 20; i++) begin
      inValid[0] = 1'b1;
      inData[0]  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      checkEq("stall_out_valid", 128'(outValid[0]), 128'd1);
      checkEq("stall_out_data", outData[0], CT128);
      checkEq("stall_in_ready", 128'(inReady[0]), 128'd0);
    end
    inValid[0]  = 1'b0;
    outReady[0] = 1'b1;
    @(posedge clk);
    #1;
    checkEq("post_hs_out_valid", 128'(outValid[0]), 128'd0);
    checkEq("post_hs_in_ready", 128'(inReady[0]), 128'd1);
    checkEq("post_hs_out_data_held", outData[0], held);
    waitDrain(0);

    // reset in the middle of round 5
    rb = {$urandom, $urandom, $urandom, $urandom};
    sendBlock(0, rb, 1'b0, modelEnc(0, rb));
    repeat (5) @(posedge clk);
    #1;
    checkEq("rk_idx_round5", 128'(rkIdx[0]), 128'd5);
    checkEq("busy_round5", 128'(busy[0]), 128'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkEq("midrst_in_ready", 128'(inReady[0]), 128'd1);
    checkEq("midrst_out_valid", 128'(outValid[0]), 128'd0);
    checkEq("midrst_busy", 128'(busy[0]), 128'd0);
    checkEq("midrst_out_data", outData[0], 128'd0);
    checkEq("midrst_rk_idx", 128'(rkIdx[0]), 128'd0);
    void'(expQ.pop_back());
    sentCnt--;
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (outValid[0]) sawValid = 1'b1;
    end
    checkEq("no_out_after_rst", 128'(sawValid), 128'd0);
    sendBlock(0, CT128, 1'b1, PT);
    waitDrain(0);

    // random back-to-back traffic with output stalls
    stallOn = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          rb   = {$urandom, $urandom, $urandom, $urandom};
          rdec = 1'($urandom_range(0, 1));
          sendBlock(0, rb, rdec, rdec ? modelDec(0, rb) : modelEnc(0, rb));
        end
        waitDrain(0);
        stallOn = 1'b0;
      end
      begin
        while (stallOn) begin
          @(posedge clk);
          #1;
          outReady[0] = ($urandom_range(0, 3) != 0);
        end
        outReady[0] = 1'b1;
      end
    join

    // encrypt-only instance ignores in_decrypt
    sendBlock(3, PT, 1'b1, CT128);
    measureLat(3, lat);
    checkEq("lat_noDec", 128'(lat), 128'd11);
    waitDrain(3);

    checkEq("results_count", 128'(popCnt), 128'(sentCnt));
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
